// File: rtl/btb_ctrl.sv
// Branch-target-buffer controller: 8x2-way BTB storage with per-set LRU, fetch lookup
// port, and a queued read-modify-write update path sharing the single storage port.
`timescale 1ns/1ps
module btb_ctrl #(
    parameter int unsigned SETS       = 8,
    parameter int unsigned INDEX_W    = 3,
    parameter int unsigned TAG_W      = 27,
    parameter int unsigned Q_DEPTH    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lk_valid,
    input  logic [31:0] lk_pc,
    output logic        lk_stall,
    output logic        lk_resp_valid,
    output logic        lk_hit,
    output logic        lk_taken,
    output logic [31:0] lk_target,
    input  logic        up_valid,
    output logic        up_ready,
    input  logic [31:0] up_pc,
    input  logic [31:0] up_target,
    input  logic        up_taken
);

    localparam int unsigned SET_W  = 128;
    localparam int unsigned TAG_LO = 63 - TAG_W;
    localparam int unsigned PTR_W  = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(Q_DEPTH + 1);
    localparam int unsigned STV_W  = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
    } upd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    // Train a hit entry: saturating 2-bit counter, target refreshed on taken.
    function automatic logic [63:0] train(input logic [63:0] e, input logic taken,
                                          input logic [31:0] tgt);
        logic [63:0] r;
        r = e;
        if (taken) begin
            r[35:4] = tgt;
            if (e[3:2] != 2'b11) r[3:2] = e[3:2] + 2'd1;
        end else begin
            if (e[3:2] != 2'b00) r[3:2] = e[3:2] - 2'd1;
        end
        return r;
    endfunction

    logic [SET_W-1:0]   mem [SETS];
    logic [SETS-1:0]    lru;
    state_t             state, state_n;
    logic [STV_W-1:0]   starve, starve_n;
    upd_t               q [Q_DEPTH];
    logic [PTR_W-1:0]   wptr, rptr;
    logic [CNT_W-1:0]   count;
    upd_t               hold_upd;
    logic [SET_W-1:0]   hold_set;
    logic               hold_lru;

    logic               full, empty, push, pop, lk_accept;
    upd_t               head;
    logic [INDEX_W-1:0] lk_idx, head_idx, acc_idx, h_idx;
    logic [TAG_W-1:0]   lk_tag, h_tag;
    logic [SET_W-1:0]   acc_set;
    logic [63:0]        lk_w1, lk_w2, h_w1, h_w2;
    logic               lk_hit1, lk_hit2, lk_hit_c, lk_way;
    logic               h_hit1, h_hit2, victim, wr_en, new_lru;
    logic [SET_W-1:0]   new_set;
    logic [63:0]        alloc;

    assign full     = (count == CNT_W'(Q_DEPTH));
    assign empty    = (count == '0);
    assign up_ready = !full;
    assign push     = up_valid && up_ready;
    assign head     = q[rptr];
    assign head_idx = head.pc[INDEX_W+1:2];

    // Single storage read port: fetch owns it in IDLE, the update path otherwise.
    assign lk_idx  = lk_pc[INDEX_W+1:2];
    assign lk_tag  = lk_pc[31:INDEX_W+2];
    assign acc_idx = (state == IDLE) ? lk_idx : head_idx;
    assign acc_set = mem[acc_idx];

    assign lk_w1     = acc_set[127:64];
    assign lk_w2     = acc_set[63:0];
    assign lk_hit1   = lk_w1[63] && (lk_w1[62:TAG_LO] == lk_tag);
    assign lk_hit2   = lk_w2[63] && (lk_w2[62:TAG_LO] == lk_tag);
    assign lk_hit_c  = lk_hit1 || lk_hit2;
    assign lk_way    = !lk_hit1;
    assign lk_accept = lk_valid && !lk_stall;

    // Arbitration FSM with bounded starvation of pending updates.
    always_comb begin
        state_n  = state;
        starve_n = starve;
        pop      = 1'b0;
        lk_stall = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && starve == STV_W'(STARVE_MAX)) begin
                    lk_stall = 1'b1;
                    state_n  = RD;
                    starve_n = '0;
                end else if (!empty && !lk_valid) begin
                    state_n  = RD;
                    starve_n = '0;
                end else if (!empty) begin
                    starve_n = starve + STV_W'(1);
                end
            end
            RD: begin
                lk_stall = 1'b1;
                pop      = 1'b1;
                state_n  = WR;
            end
            WR: begin
                lk_stall = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            starve <= '0;
        end else begin
            state  <= state_n;
            starve <= starve_n;
        end
    end

    // Update FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(Q_DEPTH); i++) q[i] <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                q[wptr] <= '{pc: up_pc, target: up_target, taken: up_taken};
                wptr    <= (wptr == PTR_W'(Q_DEPTH - 1)) ? '0 : wptr + PTR_W'(1);
            end
            if (pop) rptr <= (rptr == PTR_W'(Q_DEPTH - 1)) ? '0 : rptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // RD-stage capture of the update and its set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_upd <= '0;
            hold_set <= '0;
            hold_lru <= 1'b0;
        end else if (state == RD) begin
            hold_upd <= head;
            hold_set <= acc_set;
            hold_lru <= lru[head_idx];
        end
    end

    assign h_idx  = hold_upd.pc[INDEX_W+1:2];
    assign h_tag  = hold_upd.pc[31:INDEX_W+2];
    assign h_w1   = hold_set[127:64];
    assign h_w2   = hold_set[63:0];
    assign h_hit1 = h_w1[63] && (h_w1[62:TAG_LO] == h_tag);
    assign h_hit2 = h_w2[63] && (h_w2[62:TAG_LO] == h_tag);
    assign alloc  = {1'b1, h_tag, hold_upd.target, 2'b10, 2'b00};

    // Modify step: train a hit way, allocate on taken miss, else no write.
    always_comb begin
        wr_en   = 1'b0;
        new_set = hold_set;
        new_lru = hold_lru;
        if (!h_w1[63])      victim = 1'b0;
        else if (!h_w2[63]) victim = 1'b1;
        else                victim = ~hold_lru;
        if (h_hit1) begin
            wr_en           = 1'b1;
            new_set[127:64] = train(h_w1, hold_upd.taken, hold_upd.target);
            new_lru         = 1'b0;
        end else if (h_hit2) begin
            wr_en         = 1'b1;
            new_set[63:0] = train(h_w2, hold_upd.taken, hold_upd.target);
            new_lru       = 1'b1;
        end else if (hold_upd.taken) begin
            wr_en   = 1'b1;
            new_lru = victim;
            if (victim) new_set[63:0]   = alloc;
            else        new_set[127:64] = alloc;
        end
    end

    // Storage and LRU; lookup LRU updates never coincide with WR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(SETS); i++) mem[i] <= '0;
            lru <= '0;
        end else begin
            if (state == WR && wr_en) begin
                mem[h_idx] <= new_set;
                lru[h_idx] <= new_lru;
            end
            if (lk_accept && lk_hit_c) lru[lk_idx] <= lk_way;
        end
    end

    // Registered lookup response, valid for exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk_resp_valid <= 1'b0;
            lk_hit        <= 1'b0;
            lk_taken      <= 1'b0;
            lk_target     <= '0;
        end else begin
            lk_resp_valid <= lk_accept;
            lk_hit        <= lk_accept && lk_hit_c;
            lk_taken      <= lk_accept && lk_hit_c && (lk_hit1 ? lk_w1[3] : lk_w2[3]);
            lk_target     <= (lk_accept && lk_hit_c) ? (lk_hit1 ? lk_w1[35:4] : lk_w2[35:4])
                                                     : 32'h0;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{lk_pc[1:0], hold_upd.pc[1:0], lk_w1[2:0], lk_w2[2:0]};

endmodule

// File: tb/tb_btb_ctrl.sv
// Directed self-checking bench for btb_ctrl: lookups, training, allocation,
// starvation-bounded arbitration, queue full and reset during an RMW.
`timescale 1ns/1ps
module tb_btb_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lk_valid;
    logic [31:0] lk_pc;
    logic        lk_stall;
    logic        lk_resp_valid;
    logic        lk_hit;
    logic        lk_taken;
    logic [31:0] lk_target;
    logic        up_valid;
    logic        up_ready;
    logic [31:0] up_pc;
    logic [31:0] up_target;
    logic        up_taken;

    int vectors     = 0;
    int miscompares = 0;

    logic [9:0] stall_vec, resp_vec, hit_vec;

    always #5 clk = ~clk;

    btb_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lk_valid     (lk_valid),
        .lk_pc        (lk_pc),
        .lk_stall     (lk_stall),
        .lk_resp_valid(lk_resp_valid),
        .lk_hit       (lk_hit),
        .lk_taken     (lk_taken),
        .lk_target    (lk_target),
        .up_valid     (up_valid),
        .up_ready     (up_ready),
        .up_pc        (up_pc),
        .up_target    (up_target),
        .up_taken     (up_taken)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic e_hit,
                          input logic e_taken, input logic [31:0] e_tgt);
        lk_valid = 1'b1;
        lk_pc    = pc;
        step();
        lk_valid = 1'b0;
        chk({tag, "_rv"},  32'(lk_resp_valid), 32'd1);
        chk({tag, "_hit"}, 32'(lk_hit), 32'(e_hit));
        chk({tag, "_tk"},  32'(lk_taken), 32'(e_taken));
        chk({tag, "_tgt"}, lk_target, e_tgt);
    endtask

    // Push one update with fetch idle; it must complete IDLE->RD->WR->IDLE in 3 cycles.
    task automatic update(input string tag, input logic [31:0] pc, input logic [31:0] tgt,
                          input logic taken);
        up_valid  = 1'b1;
        up_pc     = pc;
        up_target = tgt;
        up_taken  = taken;
        step();
        up_valid = 1'b0;
        chk({tag, "_st0"}, 32'(lk_stall), 32'd0);
        step();
        chk({tag, "_st1"}, 32'(lk_stall), 32'd1);
        step();
        chk({tag, "_st2"}, 32'(lk_stall), 32'd1);
        step();
        chk({tag, "_st3"}, 32'(lk_stall), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        lk_valid  = 1'b0;
        lk_pc     = '0;
        up_valid  = 1'b0;
        up_pc     = '0;
        up_target = '0;
        up_taken  = 1'b0;
        #12;
        chk("rst_rv",    32'(lk_resp_valid), 32'd0);
        chk("rst_hit",   32'(lk_hit), 32'd0);
        chk("rst_tgt",   lk_target, 32'h0);
        chk("rst_stall", 32'(lk_stall), 32'd0);
        chk("rst_ready", 32'(up_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Cold lookup misses.
        lookup("cold", 32'h0000_0048, 1'b0, 1'b0, 32'h0);
        chk("cold_ready", 32'(up_ready), 32'd1);

        // Taken allocation, then training down to 00 and saturation at both ends.
        update("alloc", 32'h0000_0048, 32'hCAFE_BABE, 1'b1);
        lookup("lk_a", 32'h0000_0048, 1'b1, 1'b1, 32'hCAFE_BABE);
        update("nt1", 32'h0000_0048, 32'h0, 1'b0);
        lookup("lk_01", 32'h0000_0048, 1'b1, 1'b0, 32'hCAFE_BABE);
        update("nt2", 32'h0000_0048, 32'h0, 1'b0);
        lookup("lk_00", 32'h0000_0048, 1'b1, 1'b0, 32'hCAFE_BABE);
        update("nt3", 32'h0000_0048, 32'h0, 1'b0);
        update("t1", 32'h0000_0048, 32'h0BAD_F00D, 1'b1);
        lookup("lk_sat0", 32'h0000_0048, 1'b1, 1'b0, 32'h0BAD_F00D);
        update("t2", 32'h0000_0048, 32'h0BAD_F00D, 1'b1);
        update("t3", 32'h0000_0048, 32'h0BAD_F00D, 1'b1);
        update("t4", 32'h0000_0048, 32'h0BAD_F00D, 1'b1);
        update("nt4", 32'h0000_0048, 32'h0, 1'b0);
        lookup("lk_sat3", 32'h0000_0048, 1'b1, 1'b1, 32'h0BAD_F00D);

        // Three tags into index 2: third allocation evicts the way1 entry.
        pulse_reset();
        update("v08", 32'h0000_0008, 32'h1111_1000, 1'b1);
        update("v28", 32'h0000_0028, 32'h2222_2000, 1'b1);
        update("v48", 32'h0000_0048, 32'h3333_3000, 1'b1);
        lookup("lk_v08", 32'h0000_0008, 1'b0, 1'b0, 32'h0);
        lookup("lk_v28", 32'h0000_0028, 1'b1, 1'b1, 32'h2222_2000);
        lookup("lk_v48", 32'h0000_0048, 1'b1, 1'b1, 32'h3333_3000);

        // Continuous fetch with one pending update: preempts after 4 blocked cycles.
        lk_valid  = 1'b1;
        lk_pc     = 32'h0000_0100;
        up_valid  = 1'b1;
        up_pc     = 32'h0000_0100;
        up_target = 32'h1234_5678;
        up_taken  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            up_valid     = 1'b0;
            stall_vec[k] = lk_stall;
            resp_vec[k]  = lk_resp_valid;
            hit_vec[k]   = lk_hit;
        end
        lk_valid = 1'b0;
        chk("starve_stall", 32'(stall_vec), 32'h070);
        chk("starve_resp",  32'(resp_vec),  32'h31F);
        chk("starve_hit",   32'(hit_vec),   32'h300);

        // Fill the queue under fetch pressure, then reset in the middle of WR.
        lk_valid  = 1'b1;
        lk_pc     = 32'h0000_0200;
        up_valid  = 1'b1;
        up_pc     = 32'h0000_0300;
        up_target = 32'hAAAA_0000;
        up_taken  = 1'b1;
        step();
        chk("q_ready1", 32'(up_ready), 32'd1);
        up_pc     = 32'h0000_0304;
        up_target = 32'hBBBB_0000;
        step();
        chk("q_full", 32'(up_ready), 32'd0);
        up_pc = 32'h0000_0308;
        step();
        chk("q_full_hold", 32'(up_ready), 32'd0);
        up_valid = 1'b0;
        step();
        step();
        chk("q_starve", 32'(lk_stall), 32'd1);
        step();
        chk("q_rd", 32'(lk_stall), 32'd1);
        step();
        chk("q_wr", 32'(lk_stall), 32'd1);
        rst_n    = 1'b0;
        lk_valid = 1'b0;
        #1;
        chk("mid_stall", 32'(lk_stall), 32'd0);
        chk("mid_rv",    32'(lk_resp_valid), 32'd0);
        chk("mid_hit",   32'(lk_hit), 32'd0);
        chk("mid_tk",    32'(lk_taken), 32'd0);
        chk("mid_tgt",   lk_target, 32'h0);
        chk("mid_ready", 32'(up_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("post_idle", 32'(lk_stall), 32'd0);
        end
        lookup("post_300", 32'h0000_0300, 1'b0, 1'b0, 32'h0);
        lookup("post_304", 32'h0000_0304, 1'b0, 1'b0, 32'h0);
        lookup("post_100", 32'h0000_0100, 1'b0, 1'b0, 32'h0);
        lookup("post_048", 32'h0000_0048, 1'b0, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/btb_ctrl.md
Name: btb_ctrl

Overview:
Branch-target-buffer controller that owns the BTB storage: 8 sets × 2 ways, 64-bit entries, plus one LRU bit per set. It serves the fetch-stage lookup port and applies branch-resolution updates from execute. Updates are queued and applied by read-modify-write through the single storage access port. The controller arbitrates that port between fetch and updates, with a bounded-starvation rule for updates.

Parameters:
SETS, 8, number of sets (power of two)
INDEX_W, 3, log2(SETS)
TAG_W, 27, tag width = 32 - INDEX_W - 2
Q_DEPTH, 2, update queue depth
STARVE_MAX, 4, blocked cycles before a pending update preempts fetch

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
lk_valid  in  1  fetch lookup request
lk_pc  in  32  fetch PC
lk_stall  out  1  lookup not accepted this cycle; requester holds lk_pc
lk_resp_valid  out  1  lookup response valid (1 cycle after acceptance)
lk_hit  out  1  lookup hit
lk_taken  out  1  hit and state[1]
lk_target  out  32  hit target, else 0
up_valid  in  1  resolved-branch update
up_ready  out  1  queue not full
up_pc  in  32  branch PC
up_target  in  32  resolved target
up_taken  in  1  actual outcome

Behaviour:
- Clock and reset: one clock. rst_n is asynchronous and active-low. Reset clears all entries (valid=0), all LRU bits, the queue, the starve counter, FSM=IDLE, all outputs 0, up_ready=1. Reset mid-RMW discards the in-flight update.
- Address split: tag=pc[31:5], index=pc[4:2], pc[1:0] ignored.
- Entry format: {valid[63], tag[62:36], target[35:4], state[3:2], 2'b00}. Set word = {way1[127:64], way2[63:0]}.
- Hit detection: way valid and tag equal. If both ways hit, way1 has priority.
- LRU: lru[s] = most recently used way (0=way1, 1=way2).
- Victim selection: first invalid way (way1 first); if both ways are valid, the victim is ~lru[s].
- Lookup timing: accepted when lk_valid && !lk_stall. The response is registered, so lk_resp_valid/hit/taken/target appear the next cycle and hold for exactly one cycle.
- Lookup LRU side effect: a hit sets lru[index] to the hit way in the acceptance cycle.
- Queue: push when up_valid && up_ready. up_ready = !full; it stays 0 when full even if a pop occurs in the same cycle. FIFO order.
- FSM IDLE: if the queue is non-empty and (!lk_valid || starve==STARVE_MAX), go to RD. Otherwise, if the queue is non-empty and lk_valid, starve increments (saturating). starve clears on entering RD.
- FSM RD: pop the queue head; capture the set word and lru[index] into holding registers; go to WR.
- FSM WR: write the computed set word and LRU; go to IDLE.
- lk_stall = 1 in RD and WR, and in the IDLE cycle that launches RD because of starvation.
- Update rule, hit in way w: state = sat_inc(state) if up_taken, else sat_dec(state), saturating at 00 and 11. If taken, target is overwritten. lru = w.
- Update rule, miss and taken: allocate the victim with {1, tag, up_target, 2'b10}; lru = victim.
- Update rule, miss and not taken: no change. WR still occupies its cycle; the write is suppressed.
- RMW ordering: an update read in RD reflects all prior writes. A lookup resumes on the cycle after WR and sees the new contents.
- Lookup LRU writes never occur during RD or WR, so there is no same-set conflict.

Test Plan:
- Reset, then lookup pc=0x0000_0048 → one cycle later lk_resp_valid=1, lk_hit=0, lk_taken=0, lk_target=0; up_ready=1.
- Update pc=0x0000_0048, taken, target=0xCAFEBABE, lk_valid=0 → RD/WR within 3 cycles; lookup then gives hit=1, taken=1, target=0xCAFEBABE (state 10).
- Two not-taken updates to the same pc → state 10→01→00; lookups return hit=1, taken=0. A further not-taken update keeps state at 00.
- Three taken branches with distinct tags in index 2 (pcs 0x08, 0x28, 0x48), no intervening lookups → third allocation replaces the way1 entry (~lru). The first pc misses; the second and third hit.
- lk_valid held high continuously with one update queued → update launches after STARVE_MAX=4 blocked cycles; lk_stall=1 for exactly 3 cycles; all other lookups accepted.
- Two updates queued while lookups are active → up_ready=0 on a third push attempt; it deasserts rst_n mid-WR → storage all invalid, queue empty, outputs 0 immediately.
